// File: rtl/lane_scan_display_if.sv
//------------------------------------------------------------------------------
// Module      : lane_scan_display_if
// Description : Frame handshake bundle between the game logic and the display.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lane_scan_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic [2*NUM_DIGITS-1:0] obstacle;
    logic                    jump;
    logic                    frame_valid;
    logic                    frame_ready;

    modport master (
        output obstacle,
        output jump,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  obstacle,
        input  jump,
        input  frame_valid,
        output frame_ready
    );
endinterface

`default_nettype wire

// File: rtl/lane_scan_display.sv
//------------------------------------------------------------------------------
// Module      : lane_scan_display
// Description : Double-buffered, time-multiplexed seven-segment lane display
//               with collision flag and game-over blink.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lane_scan_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 32
) (
    input  wire logic                  CLK,
    input  wire logic                  RST,
    lane_scan_display_if.slave         frame,
    input  wire logic                  blink_en,
    output logic [NUM_DIGITS-1:0]      AN,
    output logic [7:0]                 S,
    output logic                       collision,
    output logic                       frame_done
);

    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_REF_W = $clog2(REFRESH_DIV);
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_OBS_W = 2 * NUM_DIGITS;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_REF_W-1:0] c_LAST_REF = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_LAST_BLK = c_BLK_W'(BLINK_DIV - 1);

    logic [c_REF_W-1:0]    r_refresh;
    logic [c_IDX_W-1:0]    r_index;
    logic [c_BLK_W-1:0]    r_blink_cnt;
    logic                  r_blank;
    logic [c_OBS_W-1:0]    r_shadow_obs;
    logic                  r_shadow_jump;
    logic                  r_full;
    logic [c_OBS_W-1:0]    r_active_obs;
    logic                  r_active_jump;
    logic                  r_collision;
    logic                  r_done;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_s;

    logic                  w_tc;
    logic                  w_wrap;
    logic [c_IDX_W-1:0]    w_pos;
    logic [1:0]            w_code;
    logic [7:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_an;
    logic                  w_shadow_coll;

    assign w_tc   = (r_refresh == c_LAST_REF);
    assign w_wrap = w_tc && (r_index == c_LAST_IDX);

    // Collision is judged on the frame about to become active.
    assign w_shadow_coll = r_shadow_jump ? r_shadow_obs[c_OBS_W-1] : r_shadow_obs[c_OBS_W-2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_refresh <= '0;
            r_index   <= '0;
        end else if (w_tc) begin
            r_refresh <= '0;
            r_index   <= w_wrap ? '0 : r_index + c_IDX_W'(1);
        end else begin
            r_refresh <= r_refresh + c_REF_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (!blink_en) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == c_LAST_BLK) begin
                r_blink_cnt <= '0;
                r_blank     <= ~r_blank;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLK_W'(1);
            end
        end
    end

    // Swap and accept are mutually exclusive: accepting needs an empty shadow,
    // swapping needs a full one, so a wrap-cycle frame waits for the next wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shadow_obs  <= '0;
            r_shadow_jump <= 1'b0;
            r_full        <= 1'b0;
            r_active_obs  <= '0;
            r_active_jump <= 1'b0;
            r_collision   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wrap && r_full) begin
                r_active_obs  <= r_shadow_obs;
                r_active_jump <= r_shadow_jump;
                r_collision   <= w_shadow_coll;
                r_done        <= 1'b1;
                r_full        <= 1'b0;
            end else if (frame.frame_valid && !r_full) begin
                r_shadow_obs  <= frame.obstacle;
                r_shadow_jump <= frame.jump;
                r_full        <= 1'b1;
            end
        end
    end

    always_comb begin
        w_pos  = c_LAST_IDX - r_index;
        w_code = r_active_obs[{w_pos, 1'b0} +: 2];
        w_seg  = 8'h00;
        w_seg[3] = w_code[0];
        w_seg[0] = w_code[1];
        if (w_pos == c_LAST_IDX) begin
            w_seg[4] = ~r_active_jump;
            w_seg[5] = r_active_jump;
            w_seg[7] = r_collision;
        end
        w_an = r_blank ? {NUM_DIGITS{1'b1}} : ~(NUM_DIGITS'(1) << w_pos);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_an <= {NUM_DIGITS{1'b1}};
            r_s  <= 8'hFF;
        end else begin
            r_an <= w_an;
            r_s  <= ~w_seg;
        end
    end

    assign AN                = r_an;
    assign S                 = r_s;
    assign collision         = r_collision;
    assign frame_done        = r_done;
    assign frame.frame_ready = ~r_full;

endmodule

`default_nettype wire

// File: tb/tb_lane_scan_display.sv
//------------------------------------------------------------------------------
// Module      : tb_lane_scan_display
// Description : Self-checking bench for lane_scan_display (4 digits, div 4/2).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lane_scan_display;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 2;
    localparam int P = N * R;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         blink_en = 1'b0;
    logic [N-1:0] AN;
    logic [7:0]   S;
    logic         collision;
    logic         frame_done;

    lane_scan_display_if #(.NUM_DIGITS(N)) bus ();

    lane_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .frame      (bus),
        .blink_en   (blink_en),
        .AN         (AN),
        .S          (S),
        .collision  (collision),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time since reset, frames as lists of lane codes.
    int cyc;
    int sh_code[N];
    int sh_jump;
    bit sh_full;
    int act_code[N];
    int act_jump;
    bit m_coll;
    bit m_done;
    int m_wraps;
    logic [N-1:0] exp_an;
    logic [7:0]   exp_s;

    typedef struct {
        logic [7:0] obs;
        logic       jump;
        logic       coll;
        logic [7:0] s_player;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            sh_code[i]  = 0;
            act_code[i] = 0;
        end
        sh_jump = 0; act_jump = 0; sh_full = 0;
        m_coll = 0; m_done = 0; m_wraps = 0;
    endtask

    task automatic step();
        int  idx, pos, seg;
        bit  wrap, blank;
        idx   = (cyc / R) % N;
        pos   = N - 1 - idx;
        wrap  = (cyc % P) == P - 1;
        blank = ((m_wraps / B) % 2) == 1;
        seg = (act_code[pos] % 2) * 8 + (act_code[pos] / 2);
        if (pos == N - 1) seg += (act_jump != 0 ? 32 : 16) + (m_coll ? 128 : 0);
        exp_an = blank ? {N{1'b1}} : N'(((1 << N) - 1) - (1 << pos));
        exp_s  = 8'(255 - seg);
        if (blink_en) begin
            if (wrap) m_wraps++;
        end else begin
            m_wraps = 0;
        end
        m_done = 0;
        if (wrap && sh_full) begin
            act_code = sh_code;
            act_jump = sh_jump;
            m_coll   = ((act_code[N-1] >> act_jump) % 2) == 1;
            m_done   = 1;
            sh_full  = 0;
        end else if (bus.frame_valid && !sh_full) begin
            for (int i = 0; i < N; i++) sh_code[i] = int'((bus.obstacle >> (2 * i)) & 8'd3);
            sh_jump = int'(bus.jump);
            sh_full = 1;
        end
        cyc++;
        @(posedge CLK);
        #1;
        check("AN", 32'(AN), 32'(exp_an));
        check("S", 32'(S), 32'(exp_s));
        check("frame_ready", 32'(bus.frame_ready), 32'(!sh_full));
        check("collision", 32'(collision), 32'(m_coll));
        check("frame_done", 32'(frame_done), 32'(m_done));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_AN"}, 32'(AN), 32'hF);
        check({tag, "_S"}, 32'(S), 32'hFF);
        check({tag, "_ready"}, 32'(bus.frame_ready), 32'h1);
        check({tag, "_coll"}, 32'(collision), 32'h0);
        check({tag, "_done"}, 32'(frame_done), 32'h0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_done && n < 3 * P);
        if (!frame_done) check("done_timeout", 32'(frame_done), 32'h1);
    endtask

    initial begin
        int n, run;
        bus.obstacle = '0; bus.jump = 1'b0; bus.frame_valid = 1'b0;

        tbl[0] = '{8'b01_10_11_00, 1'b0, 1'b1, 8'h67};
        tbl[1] = '{8'b10_00_00_00, 1'b1, 1'b1, 8'h5E};
        tbl[2] = '{8'b10_00_00_00, 1'b0, 1'b0, 8'hEE};
        tbl[3] = '{8'b01_00_00_00, 1'b1, 1'b0, 8'hD7};
        tbl[4] = '{8'b11_00_00_00, 1'b1, 1'b1, 8'h56};
        tbl[5] = '{8'b00_11_11_11, 1'b0, 1'b0, 8'hEF};

        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("reset");
        #1 RST = 1'b0;
        model_reset();

        // Table: each frame is swapped in and its player digit checked.
        for (int i = 0; i < 6; i++) begin
            bus.obstacle = tbl[i].obs; bus.jump = tbl[i].jump; bus.frame_valid = 1'b1;
            step();
            bus.frame_valid = 1'b0;
            check("tbl_accept", 32'(bus.frame_ready), 32'h0);
            wait_done(n);
            check("tbl_coll", 32'(collision), 32'(tbl[i].coll));
            step();
            check("tbl_AN", 32'(AN), 32'h7);
            check("tbl_S", 32'(S), 32'(tbl[i].s_player));
            if (i == 0) repeat (P) step();
        end

        // Back-to-back offers: second is dropped, one done per swap.
        bus.obstacle = 8'b00_01_10_11; bus.jump = 1'b1; bus.frame_valid = 1'b1;
        step();
        bus.obstacle = 8'b11_11_11_11; bus.jump = 1'b0;
        step();
        check("b2b_ready", 32'(bus.frame_ready), 32'h0);
        bus.frame_valid = 1'b0;
        n = 0;
        repeat (P + 2) begin
            step();
            if (frame_done) n++;
        end
        check("b2b_done_count", 32'(n), 32'h1);
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        check("b2b_second_accept", 32'(bus.frame_ready), 32'h0);

        // Wrap-edge acceptance with an empty shadow.
        wait_done(n);
        repeat (P - 1) step();
        bus.obstacle = 8'($urandom); bus.jump = 1'($urandom); bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        check("wrap_no_done", 32'(frame_done), 32'h0);
        wait_done(n);
        check("wrap_latency", 32'(n), 32'(P));

        // Blink runs.
        blink_en = 1'b1;
        n = 0;
        do begin step(); n++; end while (AN !== 4'hF && n < 4 * B * P);
        run = 1;
        while (run < 200) begin step(); if (AN === 4'hF) run++; else break; end
        check("blink_blank_run", 32'(run), 32'(B * P));
        run = 1;
        while (run < 200) begin step(); if (AN !== 4'hF) run++; else break; end
        check("blink_visible_run", 32'(run), 32'(B * P));
        blink_en = 1'b0;
        repeat (R) step();
        check("unblink", 32'(AN === 4'hF), 32'h0);

        // Randomised traffic with an asynchronous reset in the middle.
        for (int k = 0; k < 600; k++) begin
            bus.obstacle = 8'($urandom);
            bus.jump = 1'($urandom);
            bus.frame_valid = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            step();
            if (k == 300) begin
                #3 RST = 1'b1;
                #1 check_reset_values("async_reset");
                bus.frame_valid = 1'b0;
                repeat (3) @(posedge CLK);
                #2 RST = 1'b0;
                model_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
